// File: rtl/interrupt_acknowledge_sequencer.sv
// rtl/interrupt_acknowledge_sequencer.sv - 8259A INTA responder: counts INTA pulses,
// latches the winning level and sources CALL/vector bytes for 8086 and MCS-80 modes.
module interrupt_acknowledge_sequencer #(
  parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_acknowledge_n,
  input  logic        write_initial_command_word_1,
  input  logic        u8086_or_mcs80_config,
  input  logic        call_address_interval_4_or_8_config,
  input  logic [10:0] interrupt_vector_address,
  input  logic [7:0]  highest_level_in_request,
  input  logic        cascade_output_enable,
  output logic [7:0]  acknowledge_interrupt,
  output logic        end_of_acknowledge_sequence,
  output logic        freeze,
  output logic [7:0]  control_logic_data,
  output logic        out_control_logic_data
);

  // DONE is the single end-pulse cycle that follows the terminating INTA rise.
  typedef enum logic [2:0] {IDLE, ACK1, ACK2, ACK3, DONE} state_t;

  state_t     state;
  state_t     next_state;
  logic       inta_q;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] level_code;
  logic [2:0] level_next;
  logic       spurious;
  logic [7:0] byte_value;
  logic       byte_defined;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) inta_q <= 1'b1;
    else       inta_q <= interrupt_acknowledge_n;
  end

  assign inta_fall = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_q & interrupt_acknowledge_n;

  // An empty request is treated as a spurious IR7.
  always_comb begin
    level_next = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (highest_level_in_request[i]) level_next = i[2:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (write_initial_command_word_1) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (inta_fall) next_state = ACK1;
        ACK1: if (inta_fall) next_state = ACK2;
        ACK2: begin
          if (u8086_or_mcs80_config) begin
            if (inta_rise) next_state = DONE;
          end else if (inta_fall) begin
            next_state = ACK3;
          end
        end
        ACK3: if (inta_rise) next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_code <= 3'd0;
      spurious   <= 1'b0;
    end else if (write_initial_command_word_1 || state == DONE) begin
      level_code <= 3'd0;
      spurious   <= 1'b0;
    end else if (state == IDLE && inta_fall) begin
      level_code <= level_next;
      spurious   <= ~|highest_level_in_request;
    end
  end

  always_comb begin
    freeze                      = (state != IDLE);
    end_of_acknowledge_sequence = (state == DONE);
    acknowledge_interrupt       = 8'h00;
    if (state != IDLE && !spurious) acknowledge_interrupt = 8'h01 << level_code;

    byte_defined = 1'b0;
    byte_value   = 8'h00;
    case (state)
      ACK1: begin
        if (!u8086_or_mcs80_config) begin
          byte_defined = 1'b1;
          byte_value   = CALL_OPCODE;
        end
      end
      ACK2: begin
        byte_defined = 1'b1;
        if (u8086_or_mcs80_config)
          byte_value = {interrupt_vector_address[10:6], level_code};
        else if (call_address_interval_4_or_8_config)
          byte_value = {interrupt_vector_address[2:0], level_code, 2'b00};
        else
          byte_value = {interrupt_vector_address[2:1], level_code, 3'b000};
      end
      ACK3: begin
        if (!u8086_or_mcs80_config) begin
          byte_defined = 1'b1;
          byte_value   = interrupt_vector_address[10:3];
        end
      end
      default: begin
        byte_defined = 1'b0;
        byte_value   = 8'h00;
      end
    endcase

    out_control_logic_data = cascade_output_enable & ~interrupt_acknowledge_n & byte_defined;
    control_logic_data     = out_control_logic_data ? byte_value : 8'h00;
  end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// tb/tb_interrupt_acknowledge_sequencer.sv - self-checking bench for interrupt_acknowledge_sequencer.
module tb_interrupt_acknowledge_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        inta_n;
  logic        icw1;
  logic        mode_8086;
  logic        interval_4;
  logic [10:0] vector;
  logic [7:0]  request;
  logic        cascade_en;
  logic [7:0]  ack;
  logic        eoa;
  logic        freeze;
  logic [7:0]  data;
  logic        data_en;

  int passed = 0;
  int total  = 0;

  interrupt_acknowledge_sequencer dut (
    .clock                               (clock),
    .reset                               (reset),
    .interrupt_acknowledge_n             (inta_n),
    .write_initial_command_word_1        (icw1),
    .u8086_or_mcs80_config               (mode_8086),
    .call_address_interval_4_or_8_config (interval_4),
    .interrupt_vector_address            (vector),
    .highest_level_in_request            (request),
    .cascade_output_enable               (cascade_en),
    .acknowledge_interrupt               (ack),
    .end_of_acknowledge_sequence         (eoa),
    .freeze                              (freeze),
    .control_logic_data                  (data),
    .out_control_logic_data              (data_en)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: a sequence is "falls counted so far" against the mode's pulse count.
  logic       m_prev;
  logic       m_active;
  int         m_pulses;
  logic [7:0] m_req;
  logic       m_end;

  always @(posedge clock or posedge reset) begin
    int  need;
    logic f, r;
    if (reset) begin
      m_prev = 1'b1; m_active = 1'b0; m_pulses = 0; m_req = 8'h00; m_end = 1'b0;
    end else begin
      need = mode_8086 ? 2 : 3;
      f = m_prev & ~inta_n;
      r = ~m_prev & inta_n;
      if (icw1 || m_end) begin
        m_active = 1'b0; m_pulses = 0; m_end = 1'b0;
      end else if (!m_active) begin
        if (f) begin m_active = 1'b1; m_pulses = 1; m_req = request; end
      end else if (f && m_pulses < need) begin
        m_pulses++;
      end else if (r && m_pulses == need) begin
        m_end = 1'b1;
      end
      m_prev = inta_n;
    end
  end

  function automatic logic [2:0] level_of(input logic [7:0] req);
    level_of = 3'd7;
    for (int i = 0; i < 8; i++) if (req[i]) level_of = i[2:0];
  endfunction

  always @(negedge clock) begin
    logic [7:0] exp_byte;
    logic       defined;
    logic [2:0] lv;
    int         k;
    lv = level_of(m_req);
    k  = (m_active && !m_end) ? m_pulses : 0;
    defined  = 1'b0;
    exp_byte = 8'h00;
    if (mode_8086) begin
      if (k == 2) begin defined = 1'b1; exp_byte = {vector[10:6], lv}; end
    end else begin
      if (k == 1) begin defined = 1'b1; exp_byte = 8'hCD; end
      if (k == 2) begin
        defined  = 1'b1;
        exp_byte = interval_4 ? {vector[2:0], lv, 2'b00} : {vector[2:1], lv, 3'b000};
      end
      if (k == 3) begin defined = 1'b1; exp_byte = vector[10:3]; end
    end
    defined = defined & cascade_en & ~inta_n;
    check("m_ack", {24'd0, ack}, {24'd0, m_active ? m_req : 8'h00});
    check("m_freeze", {31'd0, freeze}, {31'd0, m_active});
    check("m_eoa", {31'd0, eoa}, {31'd0, m_end});
    check("m_data_en", {31'd0, data_en}, {31'd0, defined});
    check("m_data", {24'd0, data}, {24'd0, defined ? exp_byte : 8'h00});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pulse(input int lo, input int hi);
    inta_n = 1'b0; cyc(lo);
    inta_n = 1'b1; cyc(hi);
  endtask

  initial begin
    reset = 1'b1; inta_n = 1'b1; icw1 = 1'b0; mode_8086 = 1'b1; interval_4 = 1'b0;
    vector = 11'd0; request = 8'h00; cascade_en = 1'b1;
    cyc(2);
    check("rst_ack", {24'd0, ack}, 32'h0);
    check("rst_freeze", {31'd0, freeze}, 32'h0);
    check("rst_data_en", {31'd0, data_en}, 32'h0);
    reset = 1'b0;
    cyc(2);

    // 8086, IR3, T7..T3 = 10101
    vector = {5'b10101, 6'd0}; request = 8'h08;
    inta_n = 1'b0; cyc(1);
    check("x86_ack", {24'd0, ack}, 32'h08);
    check("x86_freeze", {31'd0, freeze}, 32'h1);
    cyc(1); inta_n = 1'b1; cyc(2);
    inta_n = 1'b0; cyc(2);
    check("x86_byte", {24'd0, data}, 32'hAB);
    check("x86_byte_en", {31'd0, data_en}, 32'h1);
    inta_n = 1'b1; cyc(1);
    check("x86_eoa", {31'd0, eoa}, 32'h1);
    check("x86_eoa_ack", {24'd0, ack}, 32'h08);
    cyc(1);
    check("x86_end_eoa", {31'd0, eoa}, 32'h0);
    check("x86_end_ack", {24'd0, ack}, 32'h0);
    check("x86_end_freeze", {31'd0, freeze}, 32'h0);
    cyc(2);

    // MCS-80, interval 4, IR2
    mode_8086 = 1'b0; interval_4 = 1'b1; vector = {8'h12, 3'b011}; request = 8'h04;
    inta_n = 1'b0; cyc(2);
    check("m80_call", {24'd0, data}, 32'hCD);
    inta_n = 1'b1; cyc(2);
    inta_n = 1'b0; cyc(2);
    check("m80_lo", {24'd0, data}, 32'h68);
    inta_n = 1'b1; cyc(2);
    check("m80_no_eoa", {31'd0, eoa}, 32'h0);
    inta_n = 1'b0; cyc(2);
    check("m80_hi", {24'd0, data}, 32'h12);
    inta_n = 1'b1; cyc(1);
    check("m80_eoa", {31'd0, eoa}, 32'h1);
    cyc(3);

    // MCS-80, interval 8, IR7
    interval_4 = 1'b0; vector = {8'h12, 3'b010}; request = 8'h80;
    pulse(2, 2);
    inta_n = 1'b0; cyc(2);
    check("m80_i8_lo", {24'd0, data}, 32'h78);
    inta_n = 1'b1; cyc(2);
    pulse(2, 3);

    // spurious in 8086 mode
    mode_8086 = 1'b1; vector = {5'b00001, 6'd0}; request = 8'h00;
    inta_n = 1'b0; cyc(1);
    check("spur_ack", {24'd0, ack}, 32'h0);
    check("spur_freeze", {31'd0, freeze}, 32'h1);
    cyc(1); inta_n = 1'b1; cyc(2);
    inta_n = 1'b0; cyc(2);
    check("spur_byte", {24'd0, data}, 32'h0F);
    inta_n = 1'b1; cyc(1);
    check("spur_eoa", {31'd0, eoa}, 32'h1);
    check("spur_eoa_ack", {24'd0, ack}, 32'h0);
    cyc(2);

    // ICW1 abort between pulses
    request = 8'h08;
    pulse(2, 2);
    icw1 = 1'b1; cyc(1); icw1 = 1'b0;
    check("icw1_freeze", {31'd0, freeze}, 32'h0);
    check("icw1_ack", {24'd0, ack}, 32'h0);
    cyc(1);
    check("icw1_no_eoa", {31'd0, eoa}, 32'h0);
    cyc(3);

    // async reset abort
    pulse(2, 2);
    reset = 1'b1; #1;
    check("rst_ab_freeze", {31'd0, freeze}, 32'h0);
    check("rst_ab_ack", {24'd0, ack}, 32'h0);
    check("rst_ab_eoa", {31'd0, eoa}, 32'h0);
    cyc(1); reset = 1'b0; cyc(2);

    // cascade disabled: no bus drive, acknowledge unchanged
    cascade_en = 1'b0; request = 8'h02; vector = {5'b11111, 6'd0};
    pulse(2, 2);
    inta_n = 1'b0; cyc(2);
    check("cas_en", {31'd0, data_en}, 32'h0);
    check("cas_data", {24'd0, data}, 32'h0);
    inta_n = 1'b1; cyc(1);
    check("cas_eoa", {31'd0, eoa}, 32'h1);
    check("cas_eoa_ack", {24'd0, ack}, 32'h02);
    cyc(2);

    // randomized sequences, cleaned up with ICW1 before any mode change
    for (int s = 0; s < 300; s++) begin
      int np;
      mode_8086  = 1'($urandom_range(0, 1));
      interval_4 = 1'($urandom_range(0, 1));
      cascade_en = ($urandom_range(0, 3) != 0);
      vector     = 11'($urandom);
      request    = ($urandom_range(0, 7) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
      np = $urandom_range(1, 4);
      for (int p = 0; p < np; p++) begin
        inta_n = 1'b0; cyc($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) request = 8'h01 << $urandom_range(0, 7);
        inta_n = 1'b1; cyc($urandom_range(1, 3));
        if ($urandom_range(0, 19) == 0) begin
          icw1 = 1'b1; cyc(1); icw1 = 1'b0;
        end else if ($urandom_range(0, 29) == 0) begin
          reset = 1'b1; cyc(1); reset = 1'b0;
        end
      end
      cyc($urandom_range(1, 3));
      icw1 = 1'b1; cyc(1); icw1 = 1'b0;
      cyc(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
